// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg -- shared types and default sizes for the data-memory arbiter.
//   arb_state_t : which requester currently has priority
//   owner_t     : which port a read issued last cycle belongs to
package dmem_arb_pkg;

   localparam int ADDR_W_DEF     = 5;
   localparam int DATA_W_DEF     = 32;
   localparam int STARVE_MAX_DEF = 4;

   typedef enum logic {
      CPU_PRI,
      DBG_PRI
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU,
      OWN_DBG
   } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr -- saturating count of consecutive refused debug-request cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : debug requested and was refused this cycle
//   clr        : debug was granted or is not requesting
//   hit        : the count being loaded this cycle equals STARVE_MAX
module arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   localparam int                CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  MAX   = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Compare against the value being loaded so the arbiter can flip
   // priority on the same edge the count arrives at STARVE_MAX.
   assign hit = (cnt_d == MAX);

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares one single-port data memory between the MEM stage
// (cpu_*) and a debug load/dump port (dbg_*). CPU has priority; a starvation
// counter forces one debug grant after STARVE_MAX refused cycles.
//   cpu_req/we/addr/wdata, dbg_*  : requests (held until granted)
//   cpu_gnt, dbg_gnt              : combinational grants, at most one high
//   cpu_stall                     : MEM stage refused this cycle
//   cpu/dbg_rvalid, _rdata        : read return one cycle after the grant
//   mem_en/we/addr/wdata          : command to the memory, from the winner
//   mem_rdata                     : memory data, valid the cycle after a read
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state_q, state_d;
   owner_t            owner_q, owner_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              starve_hit;

   // Grants are held low throughout reset so nothing reaches the memory.
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (rst_n) begin
         if (state_q == DBG_PRI) begin
            if (dbg_req)      dbg_gnt = 1'b1;
            else if (cpu_req) cpu_gnt = 1'b1;
         end else begin
            if (cpu_req)      cpu_gnt = 1'b1;
            else if (dbg_req) dbg_gnt = 1'b1;
         end
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt;

   always_comb begin
      mem_en    = cpu_gnt | dbg_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dbg_gnt) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (dbg_req & ~dbg_gnt),
      .clr   (dbg_gnt | ~dbg_req),
      .hit   (starve_hit)
   );

   // Debug priority lasts exactly one cycle, used or not.
   always_comb begin
      state_d = state_q;
      case (state_q)
         CPU_PRI: if (starve_hit) state_d = DBG_PRI;
         DBG_PRI: state_d = CPU_PRI;
         default: state_d = CPU_PRI;
      endcase
   end

   always_comb begin
      owner_d = OWN_NONE;
      if (cpu_gnt && !cpu_we)      owner_d = OWN_CPU;
      else if (dbg_gnt && !dbg_we) owner_d = OWN_DBG;
   end

   // rvalid is masked by rst_n so a read granted just before reset is dropped.
   assign cpu_rvalid = rst_n && (owner_q == OWN_CPU);
   assign dbg_rvalid = rst_n && (owner_q == OWN_DBG);

   // The owner sees mem_rdata directly; the other port keeps its last value.
   assign cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
   assign dbg_rdata   = dbg_rvalid ? mem_rdata : dbg_rdata_q;
   assign cpu_rdata_d = cpu_rdata;
   assign dbg_rdata_d = dbg_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= CPU_PRI;
         owner_q     <= OWN_NONE;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_we, dbg_req, dbg_we;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [DW-1:0] cpu_wdata, dbg_wdata;
   logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [DW-1:0] pat(int i);
      return 32'hA500_0000 + 32'(i);
   endfunction

   // Environment memory: synchronous single-port RAM, preloaded during reset.
   // Junk appears on mem_rdata whenever no read was issued.
   logic [DW-1:0] ram [32];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) ram[i] <= pat(i);
         mem_rdata <= $urandom;
      end else begin
         if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
         if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
         else                   mem_rdata <= $urandom;
      end
   end

   // Reference model state
   int            checks = 0;
   int            errors = 0;
   int            refused;      // consecutive refused debug cycles
   bit            dbg_turn;     // debug has priority this cycle
   int            pend;         // 0 none, 1 cpu, 2 dbg read due this cycle
   logic [DW-1:0] pend_data;
   logic [DW-1:0] ref_mem [32];
   logic [DW-1:0] exp_crd, exp_drd;

   // Snapshot of DUT outputs for directed literal checks
   logic          s_cgnt, s_dgnt, s_stall, s_crv, s_drv;
   logic [DW-1:0] s_crd, s_drd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_cycle();
      int            win;
      logic          ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd;
      if (!rst_n) begin
         chk("rst cpu_gnt", 32'(cpu_gnt), 0);
         chk("rst dbg_gnt", 32'(dbg_gnt), 0);
         chk("rst mem_en", 32'(mem_en), 0);
         chk("rst cpu_stall", 32'(cpu_stall), 32'(cpu_req));
         chk("rst cpu_rvalid", 32'(cpu_rvalid), 0);
         chk("rst dbg_rvalid", 32'(dbg_rvalid), 0);
         chk("rst cpu_rdata hold", cpu_rdata, exp_crd);
         chk("rst dbg_rdata hold", dbg_rdata, exp_drd);
         refused  = 0;
         dbg_turn = 0;
         pend     = 0;
         exp_crd  = '0;
         exp_drd  = '0;
         for (int i = 0; i < 32; i++) ref_mem[i] = pat(i);
      end else begin
         if (dbg_turn) win = dbg_req ? 2 : (cpu_req ? 1 : 0);
         else          win = cpu_req ? 1 : (dbg_req ? 2 : 0);
         ewe = 1'b0; ea = '0; ewd = '0;
         if (win == 1) begin ewe = cpu_we; ea = cpu_addr; ewd = cpu_wdata; end
         if (win == 2) begin ewe = dbg_we; ea = dbg_addr; ewd = dbg_wdata; end
         if (pend == 1) exp_crd = pend_data;
         if (pend == 2) exp_drd = pend_data;
         chk("cpu_gnt", 32'(cpu_gnt), 32'(win == 1));
         chk("dbg_gnt", 32'(dbg_gnt), 32'(win == 2));
         chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && win != 1));
         chk("mem_en", 32'(mem_en), 32'(win != 0));
         chk("mem_we", 32'(mem_we), 32'(ewe));
         chk("mem_addr", 32'(mem_addr), 32'(ea));
         chk("mem_wdata", mem_wdata, ewd);
         chk("cpu_rvalid", 32'(cpu_rvalid), 32'(pend == 1));
         chk("dbg_rvalid", 32'(dbg_rvalid), 32'(pend == 2));
         chk("cpu_rdata", cpu_rdata, exp_crd);
         chk("dbg_rdata", dbg_rdata, exp_drd);
         pend = 0;
         if (win != 0) begin
            if (ewe) ref_mem[ea] = ewd;
            else begin
               pend      = win;
               pend_data = ref_mem[ea];
            end
         end
         if (dbg_req && win != 2) refused = (refused < SM) ? refused + 1 : SM;
         else                     refused = 0;
         dbg_turn = !dbg_turn && (refused == SM);
      end
      s_cgnt = cpu_gnt; s_dgnt = dbg_gnt; s_stall = cpu_stall;
      s_crv = cpu_rvalid; s_drv = dbg_rvalid; s_crd = cpu_rdata; s_drd = dbg_rdata;
   endtask

   task automatic run_cycle();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic set_dbg(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
   endtask

   initial begin
      logic [5:0] cseq, dseq, sseq;
      int         n;
      bit         got;
      refused = 0; dbg_turn = 0; pend = 0; pend_data = '0;
      exp_crd = '0; exp_drd = '0;
      for (int i = 0; i < 32; i++) ref_mem[i] = pat(i);

      // Reset with both requesting
      rst_n = 1'b0;
      set_cpu(1, 0, 5'd1, '0);
      set_dbg(1, 0, 5'd2, '0);
      run_cycle();
      run_cycle();
      chk("lit rst gnt", {30'd0, s_cgnt, s_dgnt}, 0);
      chk("lit rst stall", 32'(s_stall), 1);

      // Both requesting continuously after release
      rst_n = 1'b1;
      cseq = '0; dseq = '0; sseq = '0;
      for (int c = 0; c < 6; c++) begin
         run_cycle();
         cseq = {cseq[4:0], s_cgnt};
         dseq = {dseq[4:0], s_dgnt};
         sseq = {sseq[4:0], s_stall};
      end
      chk("lit starve cpu_gnt seq", 32'(cseq), 32'b111101);
      chk("lit starve dbg_gnt seq", 32'(dseq), 32'b000010);
      chk("lit starve stall seq", 32'(sseq), 32'b000010);

      // Debug alone sweeps the whole memory
      set_cpu(0, 0, '0, '0);
      for (int i = 0; i <= 32; i++) begin
         if (i < 32) set_dbg(1, 0, AW'(i), '0);
         else        set_dbg(0, 0, '0, '0);
         run_cycle();
         if (i < 32) chk("lit sweep dbg_gnt", 32'(s_dgnt), 1);
         if (i > 0) begin
            chk("lit sweep dbg_rvalid", 32'(s_drv), 1);
            chk("lit sweep dbg_rdata", s_drd, 32'hA500_0000 + 32'(i - 1));
         end
      end

      // CPU write 3 = 42, then read it back
      set_cpu(1, 1, 5'd3, 32'd42);
      run_cycle();
      chk("lit wr gnt", 32'(s_cgnt), 1);
      set_cpu(1, 0, 5'd3, '0);
      run_cycle();
      chk("lit rd gnt", 32'(s_cgnt), 1);
      set_cpu(0, 0, '0, '0);
      run_cycle();
      chk("lit rd cpu_rvalid", 32'(s_crv), 1);
      chk("lit rd cpu_rdata", s_crd, 32'd42);
      chk("lit rd dbg_rvalid", 32'(s_drv), 0);

      // Debug drops its request after 3 refusals; the count restarts
      set_cpu(1, 0, 5'd4, '0);
      set_dbg(1, 0, 5'd5, '0);
      for (int c = 0; c < 3; c++) begin
         run_cycle();
         chk("lit drop refused", 32'(s_dgnt), 0);
      end
      dbg_req = 1'b0;
      run_cycle();
      dbg_req = 1'b1;
      n = 0; got = 0;
      while (!got && n < 20) begin
         run_cycle();
         n++;
         got = s_dgnt;
      end
      chk("lit drop restart cycles", 32'(n), 32'd5);
      set_cpu(0, 0, '0, '0);
      set_dbg(0, 0, '0, '0);
      run_cycle();

      // Randomized traffic; refused requesters hold their payload
      for (int k = 0; k < 3000; k++) begin
         if (!cpu_req || s_cgnt)
            set_cpu($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 7)), $urandom);
         if (!dbg_req || s_dgnt)
            set_dbg($urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 7)), $urandom);
         else if ($urandom_range(0, 19) == 0)
            dbg_req = 1'b0;
         run_cycle();
      end

      // Read granted, then reset on the following cycle
      set_dbg(0, 0, '0, '0);
      set_cpu(1, 1, 5'd5, 32'h1234);
      run_cycle();
      set_cpu(1, 0, 5'd5, '0);
      run_cycle();
      set_cpu(0, 0, '0, '0);
      run_cycle();
      chk("lit pre-rst cpu_rdata", s_crd, 32'h1234);
      set_cpu(1, 0, 5'd5, '0);
      run_cycle();
      chk("lit pre-rst gnt", 32'(s_cgnt), 1);
      rst_n = 1'b0;
      cpu_req = 1'b0;
      run_cycle();
      chk("lit rst drops rvalid", 32'(s_crv), 0);
      rst_n = 1'b1;
      set_cpu(1, 0, 5'd6, '0);
      set_dbg(1, 0, 5'd7, '0);
      run_cycle();
      chk("lit post-rst cpu_rdata", s_crd, 0);
      chk("lit post-rst dbg_rdata", s_drd, 0);
      chk("lit post-rst cpu first", 32'(s_cgnt), 1);
      set_cpu(0, 0, '0, '0);
      set_dbg(0, 0, '0, '0);
      run_cycle();
      run_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port, 32-word data memory between the pipeline MEM stage (CPU port) and a debug port used to load and dump memory during simulation. The CPU has priority. A starvation counter guarantees the debug port a grant after a bounded wait. Reads return one cycle after grant. Whenever the MEM stage is refused, the block raises a stall to the pipeline.

## Interface
- `ADDR_W`, 5, word address width (32 words)
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive refused debug-request cycles before the debug port is forced through (1..15)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `cpu_req`  in  1  MEM-stage access request
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  word address
- `cpu_wdata`  in  DATA_W  write data
- `cpu_gnt`  out  1  request accepted this cycle (combinational)
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`; freezes the pipeline
- `cpu_rvalid`  out  1  read data valid (registered)
- `cpu_rdata`  out  DATA_W  read data
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as the `cpu_*` ports, for the debug requester
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en & ~mem_we`

## Operation
- State machine with two states, `CPU_PRI` (reset state) and `DBG_PRI`.
- Arbitration is evaluated every cycle; at most one grant is asserted.
  - `CPU_PRI`: if `cpu_req`, the CPU wins; otherwise if `dbg_req`, debug wins.
  - `DBG_PRI`: if `dbg_req`, debug wins; otherwise the CPU wins if it is requesting.
- Memory command mux: `mem_en = cpu_gnt | dbg_gnt`. `mem_we`, `mem_addr` and `mem_wdata` are taken from the winner. When there is no winner they are driven to 0.
- Starvation counter `wait_cnt`, width `$clog2(STARVE_MAX+1)`:
  - Increments when `dbg_req & ~dbg_gnt`.
  - Clears when `dbg_gnt`, or when `dbg_req` is low.
  - Saturates at `STARVE_MAX`.
- State transitions:
  - `CPU_PRI` → `DBG_PRI` when `wait_cnt` reaches `STARVE_MAX` (the increment that makes it equal `STARVE_MAX`).
  - `DBG_PRI` → `CPU_PRI` unconditionally after one cycle, whether or not debug was granted.
- Read return:
  - A registered `owner` flag (`OWN_NONE`, `OWN_CPU`, `OWN_DBG`) is captured on every granted read.
  - The next cycle, the matching `rvalid` is 1 and its `rdata` is `mem_rdata`.
  - The non-owner `rdata` holds its previous value.
  - Writes produce no `rvalid`.
- Requests are not queued. A refused requester must hold its request and payload until it is granted.
- Back-to-back write then read to the same address from different ports returns the newly written value; the memory guarantees this, and the arbiter adds no forwarding.
- Reset (`rst_n` low at a `clk` edge):
  - State → `CPU_PRI`, `wait_cnt` → 0, `owner` → `OWN_NONE`.
  - Both `rvalid` → 0, both `rdata` → 0.
  - While `rst_n` is low, both grants and `mem_en` are forced to 0, and `cpu_stall` = `cpu_req`.
  - A read granted in the cycle before reset never produces `rvalid`.

## Timing
- Grant to memory command: 0 cycles (combinational).
- Grant to `rvalid`: 1 cycle.
- Worst-case debug wait with the CPU requesting every cycle: `STARVE_MAX` refused cycles, then a grant on the next cycle.
- Worst-case CPU stall caused by debug: 1 cycle per forced grant, plus any cycles where the CPU is idle.
- `cpu_stall` and the grants depend combinationally on the requests. No combinational path exists from `mem_rdata` to any grant.

## Structure
- Package `dmem_arb_pkg`:
  - State enum `arb_state_t` {`CPU_PRI`, `DBG_PRI`}.
  - Owner enum `owner_t` {`OWN_NONE`, `OWN_CPU`, `OWN_DBG`}.
  - Default parameter constants.
- Sub-module `arb_starve_ctr`: saturating counter with inputs `clk`, `rst_n`, `inc`, `clr` and output `hit` (count == `STARVE_MAX`). The top level holds the FSM, the mux and the read-return registers.

## Test plan
- Reset with both requests high → grants 0, `mem_en` 0, `cpu_stall` 1, `rvalid` 0. After release, the CPU is granted first.
- CPU write `addr` 3 = 42, then CPU read `addr` 3 → `cpu_rvalid` 1 and `cpu_rdata` = 42 one cycle after the read grant; `dbg_rvalid` stays 0.
- Both requesting continuously, `STARVE_MAX` = 4 → CPU granted cycles 1–4, debug granted cycle 5, `cpu_stall` high only in cycle 5, CPU granted again in cycle 6.
- Debug alone reads `addr` 0..31 sequentially → 32 consecutive grants, each `dbg_rvalid` carrying the value preloaded at that address, `wait_cnt` stays 0.
- Debug drops its request at `wait_cnt` = 3 and re-asserts it → the counter restarts from 0, with no forced grant until 4 further refused cycles.
- CPU read granted, then `rst_n` low in the next cycle → `cpu_rvalid` remains 0, state returns to `CPU_PRI`, `rdata` outputs become 0.
